// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
package riscv_pipe_pkg;

  localparam int unsigned PipeXlen = 32;
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrain
  } fetch_state_t;

  typedef struct packed {
    logic [PipeXlen-1:0] pc;
    logic [31:0]         instr;
    logic                valid;
  } if_id_t;

  // Saturating increment for event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// Pipeline register between two stages: write-enable plus a dominant flush to a bubble.
module if_id_pipe_reg
  import riscv_pipe_pkg::*;
#(
  parameter logic [31:0] BubbleInstr = NopInstr
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   write_en,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t data_q;
  if_id_t bubble;

  assign bubble = '{pc: '0, instr: BubbleInstr, valid: 1'b0};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      data_q <= bubble;
    end else if (write_en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC, variable-latency imem handshake, stall buffering and redirect draining.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush/fetch counters.
module fetch_stage_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned      XLEN      = PipeXlen,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = NopInstr
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcwrite,
  input  logic            reg_if_id_write,
  input  logic            branch_taken_ex,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_id,
  output logic [31:0]     instr_id,
  output logic            valid_id
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cyc,
  output logic [31:0]     flush_cnt,
  output logic [31:0]     fetch_cnt
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     hold_q, hold_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;
  logic            stall;
  logic            flush;
  logic            id_we;
  if_id_t          id_d, id_q;

  // A half-asserted hazard pair still freezes the stage.
  assign stall  = ~(pcwrite & reg_if_id_write);
  assign flush  = branch_taken_ex;
  assign target = branch_target & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign pc_inc = pc_q + XLEN'(4);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    id_we    = 1'b0;
    id_d     = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    imem_req = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (flush) begin
          pc_d = target;
          if (!imem_valid) state_d = StDrain;
        end else if (imem_valid) begin
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end else begin
            id_we = 1'b1;
            id_d  = '{pc: addr_q, instr: imem_rdata, valid: 1'b1};
            pc_d  = pc_inc;
          end
        end else begin
          id_we = ~stall;
        end
      end
      StHold: begin
        if (flush) begin
          pc_d    = target;
          state_d = StFetch;
        end else if (!stall) begin
          id_we   = 1'b1;
          id_d    = '{pc: pc_q, instr: hold_q, valid: 1'b1};
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StDrain: begin
        // Keep the stale request alive at its old address until memory answers.
        imem_req = 1'b1;
        if (flush) pc_d = target;
        if (imem_valid) state_d = StFetch;
        id_we = ~stall;
      end
      default: state_d = StFetch;
    endcase
    if (rst) imem_req = 1'b0;
  end

  // ADDR_Q only follows the PC when no request is left unanswered.
  always_comb begin
    addr_d = pc_d;
    if (state_q != StHold && !imem_valid) addr_d = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  if_id_pipe_reg #(
    .BubbleInstr(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .write_en(id_we),
    .flush   (flush),
    .d       (id_d),
    .q       (id_q)
  );

  assign imem_addr = addr_q;
  assign pc_id     = id_q.pc;
  assign instr_id  = id_q.instr;
  assign valid_id  = id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cyc_q, flush_cnt_q, fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      if (stall) stall_cyc_q <= sat_inc(stall_cyc_q);
      if (flush) flush_cnt_q <= sat_inc(flush_cnt_q);
      if (id_we && id_d.valid && !flush) fetch_cnt_q <= sat_inc(fetch_cnt_q);
    end
  end

  assign stall_cyc = stall_cyc_q;
  assign flush_cnt = flush_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`endif

  stall_pair_a: assert property (@(posedge clk) disable iff (rst) pcwrite == reg_if_id_write);
  valid_needs_req_a: assert property (@(posedge clk) disable iff (rst) imem_valid |-> imem_req);

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl with a variable-latency instruction memory model.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcwrite;
  logic        reg_if_id_write;
  logic        branch_taken_ex;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cyc, flush_cnt, fetch_cnt;
`endif

  int unsigned mem_delay;
  int unsigned wait_cnt;
  logic        upd_q;
  logic [31:0] sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  fetch_stage_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .pcwrite        (pcwrite),
    .reg_if_id_write(reg_if_id_write),
    .branch_taken_ex(branch_taken_ex),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .pc_id          (pc_id),
    .instr_id       (instr_id),
    .valid_id       (valid_id)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cyc      (stall_cyc),
    .flush_cnt      (flush_cnt),
    .fetch_cnt      (fetch_cnt)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory answers mem_delay cycles after a request first appears.
  always @(posedge clk) begin
    if (!imem_req || imem_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    upd_q <= (pcwrite & reg_if_id_write) | branch_taken_ex;
  end

  always_comb begin
    imem_valid = imem_req && (wait_cnt >= mem_delay);
    imem_rdata = instr_of(imem_addr);
  end

  // IF/ID only takes a new instruction on an edge that was not stalled.
  always @(negedge clk) begin
    if (!rst && valid_id && upd_q) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pc", pc_id, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("id_pc", pc_id, e);
        chk("id_instr", instr_id, instr_of(e));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    #1;
    while (!imem_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("valid_timeout", {31'b0, imem_valid}, 32'd1);
  endtask

  task automatic set_stall(input logic s);
    pcwrite         = ~s;
    reg_if_id_write = ~s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_stall(1'b0);
    branch_taken_ex = 1'b0;
    branch_target   = '0;
    mem_delay       = 0;
    step(2);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_id}, 32'd0);
    chk("rst_pc_id", pc_id, 32'd0);
    chk("rst_instr", instr_id, Nop);
    chk("rst_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_stall_cyc", stall_cyc, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
`endif

    // Zero-wait stream: one instruction per cycle.
    for (int i = 0; i < 4; i++) sb_q.push_back(32'(i * 4));
    rst = 1'b0;
    step(4);
    chk("stream_sb", 32'(sb_q.size()), 32'd0);
    chk("stream_addr", imem_addr, 32'h10);

    // Load-use stall lands on the response cycle of @0x10.
    mem_delay = 2;
    sb_q.push_back(32'h10);
    wait_valid();
    chk("stall_addr", imem_addr, 32'h10);
    set_stall(1'b1);
    step(1);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_id", {31'b0, valid_id}, 32'd0);
    set_stall(1'b0);
    step(1);
    chk("hold_sb", 32'(sb_q.size()), 32'd0);
    chk("hold_next_addr", imem_addr, 32'h14);

    // Flush with the @0x14 request outstanding.
    mem_delay = 3;
    step(1);
    branch_taken_ex = 1'b1;
    branch_target   = 32'h80;
    step(1);
    branch_taken_ex = 1'b0;
    chk("flush_bubble", {31'b0, valid_id}, 32'd0);
    chk("drain_req", {31'b0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h14);
    sb_q.push_back(32'h80);
    wait_valid();
    chk("drain_valid_addr", imem_addr, 32'h14);
    step(1);
    chk("redirect_addr", imem_addr, 32'h80);
    chk("stale_drop", {31'b0, valid_id}, 32'd0);
    wait_valid();
    step(1);
    chk("redirect_sb", 32'(sb_q.size()), 32'd0);

    // Flush and stall together while holding; unaligned target.
    wait_valid();
    chk("hold2_addr", imem_addr, 32'h84);
    set_stall(1'b1);
    step(1);
    chk("hold2_req", {31'b0, imem_req}, 32'd0);
    branch_taken_ex = 1'b1;
    branch_target   = 32'h103;
    step(1);
    branch_taken_ex = 1'b0;
    set_stall(1'b0);
    chk("hf_valid", {31'b0, valid_id}, 32'd0);
    chk("hf_addr", imem_addr, 32'h100);
    chk("hf_req", {31'b0, imem_req}, 32'd1);
    sb_q.push_back(32'h100);
    wait_valid();
    step(1);
    chk("hf_sb", 32'(sb_q.size()), 32'd0);

    // Flush coincident with a response, then PC wrap at the top of memory.
    mem_delay       = 0;
    branch_taken_ex = 1'b1;
    branch_target   = 32'hFFFF_FFFC;
    step(1);
    branch_taken_ex = 1'b0;
    chk("wrap_flush_valid", {31'b0, valid_id}, 32'd0);
    chk("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
    sb_q.push_back(32'hFFFF_FFFC);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    step(3);
    chk("wrap_sb", 32'(sb_q.size()), 32'd0);
    chk("wrap_addr", imem_addr, 32'h8);

    // Reset while draining a stale request.
    mem_delay = 4;
    step(1);
    branch_taken_ex = 1'b1;
    branch_target   = 32'h200;
    step(1);
    branch_taken_ex = 1'b0;
    chk("d2_req", {31'b0, imem_req}, 32'd1);
    chk("d2_addr", imem_addr, 32'h8);
    rst = 1'b1;
    step(1);
    chk("rst2_req", {31'b0, imem_req}, 32'd0);
    chk("rst2_valid", {31'b0, valid_id}, 32'd0);
    chk("rst2_pc_id", pc_id, 32'd0);
    chk("rst2_instr", instr_id, Nop);
    chk("rst2_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2_stall_cyc", stall_cyc, 32'd0);
    chk("rst2_flush_cnt", flush_cnt, 32'd0);
    chk("rst2_fetch_cnt", fetch_cnt, 32'd0);
`endif
    rst       = 1'b0;
    mem_delay = 0;
    sb_q.push_back(32'h0);
    step(1);
    chk("rst2_sb", 32'(sb_q.size()), 32'd0);
    chk("rst2_next_addr", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
